// File: rtl/ctrl_unit_pipe_pkg.sv
// Shared definitions for the control-unit pipeline stage: opcode values,
// ALU command encodings, decoded flag bundle and FSM state type.
package ctrl_unit_pipe_pkg;

   localparam int OP_NOP  = 0;
   localparam int OP_ADD  = 1;
   localparam int OP_SUB  = 3;
   localparam int OP_AND  = 5;
   localparam int OP_OR   = 6;
   localparam int OP_NOR  = 7;
   localparam int OP_XOR  = 8;
   localparam int OP_SLA  = 9;
   localparam int OP_SLL  = 10;
   localparam int OP_SRA  = 11;
   localparam int OP_SRL  = 12;
   localparam int OP_ADDI = 32;
   localparam int OP_SUBI = 33;
   localparam int OP_LD   = 36;
   localparam int OP_ST   = 37;
   localparam int OP_BEZ  = 40;
   localparam int OP_BNE  = 41;
   localparam int OP_JMP  = 42;

   localparam int EX_ADD = 0;
   localparam int EX_SUB = 1;
   localparam int EX_AND = 2;
   localparam int EX_OR  = 3;
   localparam int EX_NOR = 4;
   localparam int EX_XOR = 5;
   localparam int EX_SLA = 6;
   localparam int EX_SLL = 7;
   localparam int EX_SRA = 8;
   localparam int EX_SRL = 9;
   localparam int EX_BEZ = 14;
   localparam int EX_BNE = 15;
   localparam int EX_JMP = 16;

   typedef struct packed {
      logic mem_r_en;
      logic mem_w_en;
      logic wb_en;
      logic is_imm;
      logic st_or_bne;
      logic illegal;
   } ctrl_flags_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decode into an ALU command and control flags.
// Unlisted opcodes decode as a NOP with the illegal flag raised.
module ctrl_decode
   import ctrl_unit_pipe_pkg::*;
#(
   parameter int OPC_W = 6,
   parameter int CMD_W = 5
)(
   input  logic [OPC_W-1:0] opcode,
   output logic [CMD_W-1:0] exec_cmd,
   output ctrl_flags_t      flags
);

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned; that is what keeps a combinational block from becoming a latch.
   always_comb begin
      exec_cmd = '0;
      flags    = '0;
      case (int'(opcode))
         OP_NOP:  ;
         OP_ADD:  begin exec_cmd = CMD_W'(EX_ADD); flags.wb_en = 1'b1; end
         OP_SUB:  begin exec_cmd = CMD_W'(EX_SUB); flags.wb_en = 1'b1; end
         OP_AND:  begin exec_cmd = CMD_W'(EX_AND); flags.wb_en = 1'b1; end
         OP_OR:   begin exec_cmd = CMD_W'(EX_OR);  flags.wb_en = 1'b1; end
         OP_NOR:  begin exec_cmd = CMD_W'(EX_NOR); flags.wb_en = 1'b1; end
         OP_XOR:  begin exec_cmd = CMD_W'(EX_XOR); flags.wb_en = 1'b1; end
         OP_SLA:  begin exec_cmd = CMD_W'(EX_SLA); flags.wb_en = 1'b1; end
         OP_SLL:  begin exec_cmd = CMD_W'(EX_SLL); flags.wb_en = 1'b1; end
         OP_SRA:  begin exec_cmd = CMD_W'(EX_SRA); flags.wb_en = 1'b1; end
         OP_SRL:  begin exec_cmd = CMD_W'(EX_SRL); flags.wb_en = 1'b1; end
         OP_ADDI: begin exec_cmd = CMD_W'(EX_ADD); flags.wb_en = 1'b1; flags.is_imm = 1'b1; end
         OP_SUBI: begin exec_cmd = CMD_W'(EX_SUB); flags.wb_en = 1'b1; flags.is_imm = 1'b1; end
         OP_LD: begin
            exec_cmd       = CMD_W'(EX_ADD);
            flags.wb_en    = 1'b1;
            flags.is_imm   = 1'b1;
            flags.mem_r_en = 1'b1;
         end
         OP_ST: begin
            exec_cmd        = CMD_W'(EX_ADD);
            flags.is_imm    = 1'b1;
            flags.mem_w_en  = 1'b1;
            flags.st_or_bne = 1'b1;
         end
         OP_BEZ:  begin exec_cmd = CMD_W'(EX_BEZ); flags.is_imm = 1'b1; end
         OP_BNE:  begin exec_cmd = CMD_W'(EX_BNE); flags.is_imm = 1'b1; flags.st_or_bne = 1'b1; end
         OP_JMP:  begin exec_cmd = CMD_W'(EX_JMP); flags.is_imm = 1'b1; end
         default: flags.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Registered control-word stage with valid/ready handshake, load-use hazard
// detection and a one-cycle bubble FSM that counts inserted stalls.
module ctrl_unit_pipe
   import ctrl_unit_pipe_pkg::*;
#(
   parameter int OPC_W  = 6,
   parameter int CMD_W  = 5,
   parameter int REG_AW = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [REG_AW-1:0] dest,
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CMD_W-1:0]  exec_cmd,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic              is_imm,
   output logic              st_or_bne,
   output logic              illegal,
   output logic [REG_AW-1:0] out_dest,
   output logic [15:0]       stall_cnt
);

   logic [CMD_W-1:0]  dec_cmd;
   ctrl_flags_t       dec_flags;

   state_t            state_q, state_d;
   logic              ld_v_q, ld_v_d;
   logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
   logic              out_valid_q, out_valid_d;
   logic [CMD_W-1:0]  exec_cmd_q, exec_cmd_d;
   ctrl_flags_t       flags_q, flags_d;
   logic [REG_AW-1:0] out_dest_q, out_dest_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic              src2_used, hazard, slot_free, xfer_in, xfer_out, bubble_go;

   ctrl_decode #(
      .OPC_W (OPC_W),
      .CMD_W (CMD_W)
   ) u_decode (
      .opcode   (opcode),
      .exec_cmd (dec_cmd),
      .flags    (dec_flags)
   );

   // Stores read src2 even though they carry an immediate (it is the store data).
   always_comb begin
      src2_used = ~dec_flags.is_imm | (opcode == OPC_W'(OP_ST));
      hazard    = in_valid & ld_v_q & (ld_dest_q != '0) &
                  ((ld_dest_q == src1) | ((ld_dest_q == src2) & src2_used));
      slot_free = ~out_valid_q | out_ready;
      in_ready  = slot_free & ~hazard & ~flush;
      xfer_in   = in_valid & in_ready;
      xfer_out  = out_valid_q & out_ready;
      bubble_go = (state_q == ST_RUN) & hazard & slot_free;
   end

   always_comb begin
      state_d     = state_q;
      ld_v_d      = ld_v_q;
      ld_dest_d   = ld_dest_q;
      out_valid_d = out_valid_q;
      exec_cmd_d  = exec_cmd_q;
      flags_d     = flags_q;
      out_dest_d  = out_dest_q;
      stall_cnt_d = stall_cnt_q;

      if (flush) begin
         state_d     = ST_RUN;
         ld_v_d      = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bubble_go) begin
                  state_d     = ST_BUBBLE;
                  ld_v_d      = 1'b0;
                  stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
               end
            end
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
         endcase

         if (xfer_out) begin
            out_valid_d = 1'b0;
         end
         // A bubble never coincides with a transfer-in: the hazard blocks in_ready.
         if (xfer_in) begin
            out_valid_d = 1'b1;
            exec_cmd_d  = dec_cmd;
            flags_d     = dec_flags;
            out_dest_d  = dest;
            ld_v_d      = (opcode == OPC_W'(OP_LD));
            ld_dest_d   = dest;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         ld_v_q      <= 1'b0;
         ld_dest_q   <= '0;
         out_valid_q <= 1'b0;
         exec_cmd_q  <= '0;
         flags_q     <= '0;
         out_dest_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ld_v_q      <= ld_v_d;
         ld_dest_q   <= ld_dest_d;
         out_valid_q <= out_valid_d;
         exec_cmd_q  <= exec_cmd_d;
         flags_q     <= flags_d;
         out_dest_q  <= out_dest_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign exec_cmd  = exec_cmd_q;
   assign mem_r_en  = flags_q.mem_r_en;
   assign mem_w_en  = flags_q.mem_w_en;
   assign wb_en     = flags_q.wb_en;
   assign is_imm    = flags_q.is_imm;
   assign st_or_bne = flags_q.st_or_bne;
   assign illegal   = flags_q.illegal;
   assign out_dest  = out_dest_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Self-checking bench for ctrl_unit_pipe: directed scenarios plus a random
// instruction stream scored against a transaction-level reference model.
module tb_ctrl_unit_pipe;

   localparam int OP_ADD  = 1;
   localparam int OP_SUB  = 3;
   localparam int OP_ADDI = 32;
   localparam int OP_LD   = 36;
   localparam int OP_ST   = 37;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [5:0]  opcode;
   logic [4:0]  dest, src1, src2, out_dest, exec_cmd;
   logic        mem_r_en, mem_w_en, wb_en, is_imm, st_or_bne, illegal;
   logic [15:0] stall_cnt;
   logic [15:0] act_word;

   int total = 0;
   int bad   = 0;

   // Listed opcodes and the ALU command each one selects.
   int legal_ops [17] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
   int legal_cmd [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 0, 0, 14, 15, 16};

   always #5 clk = ~clk;

   ctrl_unit_pipe #(.OPC_W(6), .CMD_W(5), .REG_AW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .dest      (dest),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .exec_cmd  (exec_cmd),
      .mem_r_en  (mem_r_en),
      .mem_w_en  (mem_w_en),
      .wb_en     (wb_en),
      .is_imm    (is_imm),
      .st_or_bne (st_or_bne),
      .illegal   (illegal),
      .out_dest  (out_dest),
      .stall_cnt (stall_cnt)
   );

   assign act_word = {exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, st_or_bne, illegal, out_dest};

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic int find_legal(input int op);
      for (int i = 0; i < 17; i++)
         if (legal_ops[i] == op) return i;
      return -1;
   endfunction

   // Expected control word {cmd, r, w, wb, imm, st_or_bne, illegal, dest}.
   function automatic logic [15:0] model_word(input int op, input int d);
      int         k;
      logic [4:0] ex;
      logic       r, w, wb, im, sb, il;
      k  = find_legal(op);
      ex = '0; r = 0; w = 0; wb = 0; im = 0; sb = 0; il = 0;
      if (k >= 0) begin
         ex = 5'(legal_cmd[k]);
         im = (op >= 32);
         r  = (op == 36);
         w  = (op == 37);
         sb = (op == 37) || (op == 41);
         wb = !((op == 37) || (op >= 40));
      end else begin
         il = (op != 0);
      end
      return {ex, r, w, wb, im, sb, il, 5'(d)};
   endfunction

   function automatic bit depends(input int pop, input int pd, input int op, input int s1, input int s2);
      bit src2_read;
      src2_read = !((find_legal(op) >= 0) && (op >= 32)) || (op == OP_ST);
      return (pop == OP_LD) && (pd != 0) && ((pd == s1) || ((pd == s2) && src2_read));
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opcode = '0; dest = '0; src1 = '0; src2 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Present one instruction and hold it until accepted; returns cycles waited.
   task automatic issue(input int op, input int d, input int s1, input int s2, output int waits);
      in_valid = 1'b1; opcode = 6'(op); dest = 5'(d); src1 = 5'(s1); src2 = 5'(s2);
      waits = 0;
      #1;
      while (in_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (in_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL issue_timeout op=%0d in_ready=%b after %0d cycles", op, in_ready, waits);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      int w;
      issue(OP_LD, 9, 0, 0, w);
      rst = 1'b1; in_valid = 1'b1; opcode = 6'(OP_ADD); dest = 5'd3;
      flush = 1'($urandom_range(0, 1)); out_ready = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++;
      if (act_word !== 16'h0) begin bad++; $display("FAIL reset_ctrl_word got=%h exp=0000", act_word); end
      total++;
      if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_decode_sweep();
      int          w, d;
      logic [15:0] exp;
      do_reset();
      for (int op = 0; op < 64; op++) begin
         d = $urandom_range(0, 31);
         issue(op, d, 0, 0, w);
         exp = model_word(op, d);
         total++;
         if (out_valid !== 1'b1 || act_word !== exp || w != 0) begin
            bad++;
            $display("FAIL decode op=%0d got=%h valid=%b waits=%0d exp=%h valid=1 waits=0",
                     op, act_word, out_valid, w, exp);
         end
      end
      issue(2, 4, 0, 0, w);
      total++;
      if (illegal !== 1'b1 || exec_cmd !== 5'd0 || wb_en !== 1'b0) begin
         bad++;
         $display("FAIL opcode2_illegal got illegal=%b cmd=%0d wb=%b exp illegal=1 cmd=0 wb=0",
                  illegal, exec_cmd, wb_en);
      end
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL sweep_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_load_use();
      int w;
      do_reset();
      issue(OP_LD, 5, 0, 0, w);
      total++;
      if (out_valid !== 1'b1 || act_word !== model_word(OP_LD, 5)) begin
         bad++; $display("FAIL lu_ld_word got=%h valid=%b exp=%h", act_word, out_valid, model_word(OP_LD, 5));
      end
      in_valid = 1'b1; opcode = 6'(OP_ADD); dest = 5'd2; src1 = 5'd5; src2 = 5'd0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_hazard_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%b exp=0", out_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || act_word !== model_word(OP_ADD, 2)) begin
         bad++; $display("FAIL lu_add_two_cycles got=%h valid=%b exp=%h", act_word, out_valid, model_word(OP_ADD, 2));
      end
      @(negedge clk);
      #1;
      total++;
      if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
   endtask

   task automatic test_ld_zero();
      int w;
      do_reset();
      issue(OP_LD, 0, 0, 0, w);
      issue(OP_ADD, 4, 0, 0, w);
      total++;
      if (w != 0 || act_word !== model_word(OP_ADD, 4)) begin
         bad++; $display("FAIL ldzero_no_bubble waits=%0d got=%h exp waits=0 word=%h", w, act_word, model_word(OP_ADD, 4));
      end
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ldzero_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_imm_vs_store();
      int w;
      do_reset();
      issue(OP_LD, 7, 0, 0, w);
      issue(OP_ADDI, 3, 0, 7, w);
      total++;
      if (w != 0 || act_word !== model_word(OP_ADDI, 3)) begin
         bad++; $display("FAIL addi_src2_no_stall waits=%0d got=%h exp waits=0 word=%h", w, act_word, model_word(OP_ADDI, 3));
      end
      issue(OP_LD, 7, 0, 0, w);
      issue(OP_ST, 0, 1, 7, w);
      total++;
      if (w != 1 || act_word !== model_word(OP_ST, 0)) begin
         bad++; $display("FAIL st_src2_one_bubble waits=%0d got=%h exp waits=1 word=%h", w, act_word, model_word(OP_ST, 0));
      end
      total++;
      if (stall_cnt !== 16'd1) begin bad++; $display("FAIL imm_store_stall_cnt got=%0d exp=1", stall_cnt); end
   endtask

   task automatic test_backpressure();
      int          w;
      logic [15:0] exp;
      do_reset();
      out_ready = 1'b0;
      issue(OP_ADD, 3, 1, 2, w);
      exp = model_word(OP_ADD, 3);
      in_valid = 1'b1; opcode = 6'(OP_SUB); dest = 5'd4; src1 = 5'd0; src2 = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || act_word !== exp || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle=%0d got=%h valid=%b in_ready=%b exp=%h valid=1 in_ready=0",
                     i, act_word, out_valid, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || act_word !== model_word(OP_SUB, 4)) begin
         bad++; $display("FAIL bp_next_word got=%h valid=%b exp=%h", act_word, out_valid, model_word(OP_SUB, 4));
      end
   endtask

   task automatic test_flush();
      int w;
      do_reset();
      out_ready = 1'b0;
      issue(OP_LD, 5, 0, 0, w);
      in_valid = 1'b1; opcode = 6'(OP_ADD); dest = 5'd6; src1 = 5'd5; src2 = 5'd0; flush = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ld_cleared in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || act_word !== model_word(OP_ADD, 6)) begin
         bad++; $display("FAIL flush_dep_issue got=%h valid=%b exp=%h", act_word, out_valid, model_word(OP_ADD, 6));
      end
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_reset_mid_bubble();
      int w;
      do_reset();
      issue(OP_LD, 5, 0, 0, w);
      in_valid = 1'b1; opcode = 6'(OP_ADD); dest = 5'd6; src1 = 5'd5; src2 = 5'd0;
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rmb_in_bubble valid got=%b exp=0", out_valid); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || act_word !== 16'h0 || stall_cnt !== 16'h0) begin
         bad++; $display("FAIL rmb_cleared valid=%b word=%h stall=%0d exp 0/0000/0", out_valid, act_word, stall_cnt);
      end
      rst = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rmb_run_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || act_word !== model_word(OP_ADD, 6)) begin
         bad++; $display("FAIL rmb_after_reset got=%h valid=%b exp=%h", act_word, out_valid, model_word(OP_ADD, 6));
      end
   endtask

   task automatic test_random_stream();
      logic [15:0] exp_q [$];
      logic [15:0] e;
      int          pool [8] = '{OP_LD, OP_LD, OP_ADD, OP_ST, OP_ADDI, 41, 2, 8};
      int          exp_stalls, n_in, cycles, op, d, s1, s2, pop, pd;
      exp_stalls = 0; n_in = 0; cycles = 0; pop = 0; pd = 0;
      do_reset();
      op = pool[$urandom_range(0, 7)];
      d  = $urandom_range(0, 3); s1 = $urandom_range(0, 3); s2 = $urandom_range(0, 3);
      while (n_in < 300 && cycles < 5000) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         opcode    = 6'(op); dest = 5'(d); src1 = 5'(s1); src2 = 5'(s2);
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (out_valid === 1'b1 && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rnd_unexpected_word got=%h", act_word);
            end else begin
               e = exp_q.pop_front();
               if (act_word !== e) begin bad++; $display("FAIL rnd_word got=%h exp=%h", act_word, e); end
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(model_word(op, d));
            if (n_in > 0 && depends(pop, pd, op, s1, s2)) exp_stalls++;
            pop = op; pd = d; n_in++;
            op = pool[$urandom_range(0, 7)];
            d  = $urandom_range(0, 3); s1 = $urandom_range(0, 3); s2 = $urandom_range(0, 3);
         end
         @(negedge clk);
         cycles++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() > 0 && cycles < 5100) begin
         #1;
         if (out_valid === 1'b1) begin
            e = exp_q.pop_front();
            total++;
            if (act_word !== e) begin bad++; $display("FAIL rnd_drain_word got=%h exp=%h", act_word, e); end
         end
         @(negedge clk);
         cycles++;
      end
      #1;
      total++;
      if (n_in != 300 || exp_q.size() != 0) begin
         bad++; $display("FAIL rnd_progress accepted=%0d pending=%0d exp 300/0", n_in, exp_q.size());
      end
      total++;
      if (stall_cnt !== 16'(exp_stalls)) begin
         bad++; $display("FAIL rnd_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stalls);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opcode = '0; dest = '0; src1 = '0; src2 = '0;
      do_reset();
      test_reset();
      test_decode_sweep();
      test_load_use();
      test_ld_zero();
      test_imm_vs_store();
      test_backpressure();
      test_flush();
      test_reset_mid_bubble();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
